// File: rtl/l1_dcache_assoc.sv
// Write-back, write-allocate L1 data cache with 1- or 2-way associativity and LRU replacement.
// Lookup is combinational in IDLE; misses walk WRITEBACK/ALLOCATE, then replay as a hit.
module l1_dcache_assoc #(
  parameter int LINE_BITS = 256,
  parameter int SETS      = 32,
  parameter int WAYS      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o,
  output logic [31:0]          wb_cnt_o
);
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = 32 - IDX - OFF;
  localparam int WORDS = LINE_BITS / 32;
  localparam int WSEL  = OFF - 2;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]             state;
  logic [SETS-1:0]        valid [WAYS];
  logic [SETS-1:0]        dirty [WAYS];
  logic [SETS-1:0]        lru;
  logic [TAG-1:0]         tag_mem  [WAYS][SETS];
  logic [WORDS-1:0][31:0] line_mem [WAYS][SETS];

  logic                 victim_q;
  logic [TAG+IDX-1:0]   miss_line_q;

  logic [TAG-1:0]       req_tag;
  logic [IDX-1:0]       req_idx;
  logic [WSEL-1:0]      req_word;
  logic [IDX-1:0]       miss_idx;
  logic [TAG-1:0]       miss_tag;
  logic                 unused_addr_bits;

  assign req_tag          = p1_addr_i[31 -: TAG];
  assign req_idx          = p1_addr_i[OFF +: IDX];
  assign req_word         = p1_addr_i[2 +: WSEL];
  assign miss_idx         = miss_line_q[IDX-1:0];
  assign miss_tag         = miss_line_q[TAG+IDX-1:IDX];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  logic                   hit;
  logic                   hit_way;
  logic [WORDS-1:0][31:0] hit_line;
  logic                   victim;
  logic                   victim_dirty;

  // Victim preference: lowest-numbered invalid way, otherwise the LRU way.
  always_comb begin
    hit          = 1'b0;
    hit_way      = 1'b0;
    hit_line     = '0;
    victim       = (WAYS == 2) ? lru[req_idx] : 1'b0;
    victim_dirty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][req_idx]) victim = 1'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_line = line_mem[w][req_idx];
      end
      if (victim == 1'(w)) victim_dirty = valid[w][req_idx] & dirty[w][req_idx];
    end
  end

  logic [TAG-1:0]         vic_tag;
  logic [WORDS-1:0][31:0] vic_line;

  always_comb begin
    vic_tag  = '0;
    vic_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (victim_q == 1'(w)) begin
        vic_tag  = tag_mem[w][miss_idx];
        vic_line = line_mem[w][miss_idx];
      end
    end
  end

  logic req, in_idle, idle_hit, idle_miss;

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign in_idle   = (state == IDLE);
  assign idle_hit  = in_idle & req & hit;
  assign idle_miss = in_idle & req & ~hit;

  assign p1_stall_o   = req & (~in_idle | ~hit);
  assign p1_data_o    = (idle_hit & p1_MemRead_i & ~p1_MemWrite_i) ? hit_line[req_word] : 32'd0;
  assign mem_enable_o = (state == WRITEBACK) | (state == ALLOCATE);
  assign mem_write_o  = (state == WRITEBACK);
  assign mem_data_o   = (state == WRITEBACK) ? vic_line : '0;

  always_comb begin
    mem_addr_o = 32'd0;
    if (state == WRITEBACK) mem_addr_o = {vic_tag, miss_idx, {OFF{1'b0}}};
    else if (state == ALLOCATE) mem_addr_o = {miss_tag, miss_idx, {OFF{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lru         <= '0;
      victim_q    <= 1'b0;
      miss_line_q <= '0;
      hit_cnt_o   <= 32'd0;
      miss_cnt_o  <= 32'd0;
      wb_cnt_o    <= 32'd0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit) begin
            hit_cnt_o <= hit_cnt_o + 32'd1;
            if (WAYS == 2) lru[req_idx] <= ~hit_way;
            for (int w = 0; w < WAYS; w++) begin
              if (p1_MemWrite_i && hit_way == 1'(w)) dirty[w][req_idx] <= 1'b1;
            end
          end else if (idle_miss) begin
            miss_cnt_o  <= miss_cnt_o + 32'd1;
            victim_q    <= victim;
            miss_line_q <= p1_addr_i[31:OFF];
            state       <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            wb_cnt_o <= wb_cnt_o + 32'd1;
            for (int w = 0; w < WAYS; w++) begin
              if (victim_q == 1'(w)) dirty[w][miss_idx] <= 1'b0;
            end
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            for (int w = 0; w < WAYS; w++) begin
              if (victim_q == 1'(w)) begin
                valid[w][miss_idx] <= 1'b1;
                dirty[w][miss_idx] <= 1'b0;
              end
            end
            if (WAYS == 2) lru[miss_idx] <= ~victim_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line and tag storage carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        if (idle_hit && p1_MemWrite_i && hit_way == 1'(w))
          line_mem[w][req_idx][req_word] <= p1_data_i;
        if (state == ALLOCATE && mem_ack_i && victim_q == 1'(w)) begin
          line_mem[w][miss_idx] <= mem_data_i;
          tag_mem[w][miss_idx]  <= miss_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache_assoc.sv
// Scoreboard bench: a 2-way default cache (A) and a direct-mapped 8-set, 128-bit cache (B),
// each with a reactive line memory that checks expected external transactions.
module tb_l1_dcache_assoc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  addr_a, data_a, p1_data_out_a, mem_addr_a, hit_a, miss_a, wb_a;
  logic         rd_a, wr_a, stall_a, mem_enable_a, mem_write_a, mem_ack_a;
  logic [255:0] mem_data_out_a, mem_data_in_a;

  logic [31:0]  addr_b, data_b, p1_data_out_b, mem_addr_b, hit_b, miss_b, wb_b;
  logic         rd_b, wr_b, stall_b, mem_enable_b, mem_write_b, mem_ack_b;
  logic [127:0] mem_data_out_b, mem_data_in_b;

  l1_dcache_assoc dut_a (
    .clk(clk), .rst(rst), .p1_addr_i(addr_a), .p1_data_i(data_a),
    .p1_MemRead_i(rd_a), .p1_MemWrite_i(wr_a), .p1_data_o(p1_data_out_a),
    .p1_stall_o(stall_a), .mem_addr_o(mem_addr_a), .mem_data_o(mem_data_out_a),
    .mem_data_i(mem_data_in_a), .mem_enable_o(mem_enable_a), .mem_write_o(mem_write_a),
    .mem_ack_i(mem_ack_a), .hit_cnt_o(hit_a), .miss_cnt_o(miss_a), .wb_cnt_o(wb_a)
  );

  l1_dcache_assoc #(.LINE_BITS(128), .SETS(8), .WAYS(1)) dut_b (
    .clk(clk), .rst(rst), .p1_addr_i(addr_b), .p1_data_i(data_b),
    .p1_MemRead_i(rd_b), .p1_MemWrite_i(wr_b), .p1_data_o(p1_data_out_b),
    .p1_stall_o(stall_b), .mem_addr_o(mem_addr_b), .mem_data_o(mem_data_out_b),
    .mem_data_i(mem_data_in_b), .mem_enable_o(mem_enable_b), .mem_write_o(mem_write_b),
    .mem_ack_i(mem_ack_b), .hit_cnt_o(hit_b), .miss_cnt_o(miss_b), .wb_cnt_o(wb_b)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          widx;
    logic [31:0] wval;
  } mem_exp_t;

  mem_exp_t    exp_mem_a[$];
  logic [31:0] exp_mem_b[$];
  logic [31:0] exp_rd_a[$];
  logic [31:0] exp_rd_b[$];
  logic [255:0] model [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int ack_delay = 10;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Issue one access at posedge+1, hold it until the stall drops, release after the next edge.
  task automatic applyStimulus(input bit sel, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input bit exp_miss);
    int budget;
    if (sel) begin rd_b = rd; wr_b = wr; addr_b = addr; data_b = data; end
    else     begin rd_a = rd; wr_a = wr; addr_a = addr; data_a = data; end
    @(negedge clk);
    checkOutput(sel ? "stall_first_b" : "stall_first_a", 32'(sel ? stall_b : stall_a), 32'(exp_miss));
    budget = 0;
    while ((sel ? stall_b : stall_a) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 400) failNow("stall_timeout");
    @(posedge clk);
    #1;
    if (sel) begin rd_b = 1'b0; wr_b = 1'b0; end
    else     begin rd_a = 1'b0; wr_a = 1'b0; end
  endtask

  task automatic doRead(input bit sel, input logic [31:0] addr, input bit exp_miss,
                        input logic [31:0] exp_data);
    if (sel) exp_rd_b.push_back(exp_data);
    else     exp_rd_a.push_back(exp_data);
    applyStimulus(sel, 1'b1, 1'b0, addr, 32'd0, exp_miss);
  endtask

  task automatic expMem(input bit wr, input logic [31:0] addr, input int widx, input logic [31:0] wval);
    mem_exp_t m;
    m.wr = wr; m.addr = addr; m.widx = widx; m.wval = wval;
    exp_mem_a.push_back(m);
  endtask

  task automatic resetDut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic checkCounters(input logic [31:0] h, input logic [31:0] m, input logic [31:0] w);
    checkOutput("hit_cnt_a", hit_a, h);
    checkOutput("miss_cnt_a", miss_a, m);
    checkOutput("wb_cnt_a", wb_a, w);
  endtask

  // Read-data monitor: a completed (unstalled) read pops the scoreboard.
  always @(negedge clk) begin
    if (rd_a && !wr_a && !stall_a) begin
      if (exp_rd_a.size() == 0) failNow("rd_unexpected_a");
      else checkOutput("rd_data_a", p1_data_out_a, exp_rd_a.pop_front());
    end
    if (rd_b && !wr_b && !stall_b) begin
      if (exp_rd_b.size() == 0) failNow("rd_unexpected_b");
      else checkOutput("rd_data_b", p1_data_out_b, exp_rd_b.pop_front());
    end
  end

  // External memory for A: check each request, then ack after ack_delay unless reset intervenes.
  always begin
    mem_exp_t m;
    bit aborted;
    @(negedge clk);
    if (mem_enable_a && !rst) begin
      if (exp_mem_a.size() == 0) failNow("mem_unexpected_a");
      else begin
        m = exp_mem_a.pop_front();
        checkOutput("mem_write_a", 32'(mem_write_a), 32'(m.wr));
        checkOutput("mem_addr_a", mem_addr_a, m.addr);
        if (m.wr) checkOutput("wb_word_a", mem_data_out_a[m.widx*32 +: 32], m.wval);
      end
      aborted = 1'b0;
      for (int i = 0; i < ack_delay; i++) begin
        @(negedge clk);
        if (rst) begin aborted = 1'b1; break; end
      end
      if (!aborted) begin
        if (mem_write_a) model[mem_addr_a] = mem_data_out_a;
        else mem_data_in_a = model.exists(mem_addr_a) ? model[mem_addr_a] : '0;
        mem_ack_a = 1'b1;
        @(negedge clk);
        mem_ack_a = 1'b0;
      end
    end
  end

  // External memory for B: read-only expected; refill word k holds line address + k.
  always begin
    @(negedge clk);
    if (mem_enable_b && !rst) begin
      checkOutput("mem_write_b", 32'(mem_write_b), 32'd0);
      if (exp_mem_b.size() == 0) failNow("mem_unexpected_b");
      else checkOutput("mem_addr_b", mem_addr_b, exp_mem_b.pop_front());
      for (int k = 0; k < 4; k++) mem_data_in_b[k*32 +: 32] = mem_addr_b + 32'(k);
      repeat (3) @(negedge clk);
      mem_ack_b = 1'b1;
      @(negedge clk);
      mem_ack_b = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] ln;
    int budget;
    rst = 1'b1;
    rd_a = 0; wr_a = 0; addr_a = 0; data_a = 0; mem_ack_a = 0; mem_data_in_a = '0;
    rd_b = 0; wr_b = 0; addr_b = 0; data_b = 0; mem_ack_b = 0; mem_data_in_b = '0;
    ln = '0;
    ln[95:64] = 32'hDEADBEEF;
    model[32'h40] = ln;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_stall", 32'(stall_a), 32'd0);
    checkOutput("rst_data", p1_data_out_a, 32'd0);
    checkOutput("rst_mem_en", 32'(mem_enable_a), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_write_a), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_a, 32'd0);
    checkCounters(0, 0, 0);
    @(posedge clk); #1;

    $display("[TB] clean miss, refill, replay and same-line hit");
    expMem(0, 32'h40, 0, 0);
    doRead(0, 32'h40, 1, 32'h0);
    doRead(0, 32'h48, 0, 32'hDEADBEEF);
    checkCounters(2, 1, 0);

    $display("[TB] write hit, fill way 1, evict dirty LRU way 0");
    applyStimulus(0, 0, 1, 32'h44, 32'h12345678, 0);
    expMem(0, 32'h440, 0, 0);
    doRead(0, 32'h440, 1, 32'h0);
    expMem(1, 32'h40, 1, 32'h12345678);
    expMem(0, 32'h840, 0, 0);
    doRead(0, 32'h840, 1, 32'h0);
    checkCounters(5, 3, 1);

    $display("[TB] LRU follows the most recent hit");
    resetDut();
    checkCounters(0, 0, 0);
    expMem(0, 32'h40, 0, 0);
    doRead(0, 32'h40, 1, 32'h0);
    expMem(0, 32'h440, 0, 0);
    doRead(0, 32'h440, 1, 32'h0);
    doRead(0, 32'h40, 0, 32'h0);
    expMem(0, 32'h840, 0, 0);
    doRead(0, 32'h840, 1, 32'h0);
    doRead(0, 32'h44, 0, 32'h12345678);
    checkCounters(5, 3, 0);

    $display("[TB] reset in the middle of a writeback");
    applyStimulus(0, 0, 1, 32'h44, 32'h0BADF00D, 0);
    doRead(0, 32'h840, 0, 32'h0);
    expMem(1, 32'h40, 1, 32'h0BADF00D);
    ack_delay = 40;
    rd_a = 1'b1; addr_a = 32'h440;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(mem_enable_a && mem_write_a) && budget < 20);
    if (budget >= 20) failNow("wb_start_timeout");
    @(posedge clk); #1 rst = 1'b1; rd_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_wb_mem_en", 32'(mem_enable_a), 32'd0);
    checkOutput("rst_wb_mem_wr", 32'(mem_write_a), 32'd0);
    checkCounters(0, 0, 0);
    ack_delay = 10;
    @(posedge clk); #1;
    expMem(0, 32'h40, 0, 0);
    doRead(0, 32'h40, 1, 32'h0);
    doRead(0, 32'h44, 0, 32'h12345678);

    $display("[TB] simultaneous read and write is a write");
    applyStimulus(0, 1, 1, 32'h40, 32'hA5A5A5A5, 0);
    doRead(0, 32'h40, 0, 32'hA5A5A5A5);
    expMem(0, 32'h440, 0, 0);
    doRead(0, 32'h440, 1, 32'h0);
    expMem(1, 32'h40, 0, 32'hA5A5A5A5);
    expMem(0, 32'h840, 0, 0);
    doRead(0, 32'h840, 1, 32'h0);
    checkOutput("wb_cnt_rw", wb_a, 32'd1);

    $display("[TB] direct-mapped conflict misses, no writeback");
    exp_mem_b.push_back(32'h000);
    doRead(1, 32'h000, 1, 32'h0);
    exp_mem_b.push_back(32'h080);
    doRead(1, 32'h084, 1, 32'h81);
    checkOutput("miss_cnt_b", miss_b, 32'd2);
    checkOutput("wb_cnt_b", wb_b, 32'd0);
    exp_mem_b.push_back(32'h000);
    doRead(1, 32'h008, 1, 32'h2);
    checkOutput("hit_cnt_b", hit_b, 32'd3);

    repeat (3) @(negedge clk);
    checkOutput("rd_queue_a_left", 32'(exp_rd_a.size()), 32'd0);
    checkOutput("mem_queue_a_left", 32'(exp_mem_a.size()), 32'd0);
    checkOutput("rd_queue_b_left", 32'(exp_rd_b.size()), 32'd0);
    checkOutput("mem_queue_b_left", 32'(exp_mem_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_dcache_assoc.md
Name: l1_dcache_assoc

Overview:
Parametrised, write-back, write-allocate L1 data cache. It sits between the CPU MEM stage (EX/MEM ALU result as the address, EX/MEM store data) and the external line-wide data memory. It generalises the current direct-mapped cache to configurable sets, line width and 1- or 2-way associativity, with LRU replacement and hit/miss/writeback counters. While p1_stall_o is high, every pipeline latch and the PC freeze.

Parameters:
LINE_BITS, 256, cache line width in bits; power of two, at least 64.
SETS, 32, number of sets; power of two.
WAYS, 2, associativity; legal values are 1 and 2.
Derived: OFF = log2(LINE_BITS/8); IDX = log2(SETS); TAG = 32-IDX-OFF.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
p1_addr_i  in  32  byte address from the CPU.
p1_data_i  in  32  store data.
p1_MemRead_i  in  1  load request.
p1_MemWrite_i  in  1  store request; takes priority when both requests are high.
p1_data_o  out  32  load data.
p1_stall_o  out  1  pipeline freeze.
mem_addr_o  out  32  line-aligned external address; low OFF bits are zero.
mem_data_o  out  LINE_BITS  writeback line.
mem_data_i  in  LINE_BITS  refill line.
mem_enable_o  out  1  external request.
mem_write_o  out  1  1 = write, 0 = read.
mem_ack_i  in  1  one-cycle completion pulse from external memory.
hit_cnt_o  out  32  hit counter; wraps.
miss_cnt_o  out  32  miss counter; wraps.
wb_cnt_o  out  32  writeback counter; wraps.

Behaviour:
- Address fields: tag = addr[31:OFF+IDX]; index = addr[OFF+IDX-1:OFF]; word = addr[OFF-1:2]. addr[1:0] is ignored; only word accesses are supported.
- Per way and set the cache holds valid, dirty, tag and line. Each set holds one LRU bit naming the least-recently-used way; for WAYS=1 it is unused and tied to 0.
- Reset (synchronous, from any state): state goes to IDLE; all valid, dirty and LRU bits clear; counters go to 0; mem_enable_o and mem_write_o go low on the next edge. Line data is not cleared. Dirty data in flight is discarded.
- Outputs after reset: p1_stall_o=0, p1_data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit (valid and tag match in any way):
  - Combinational, zero-latency: a read drives the selected word on p1_data_o in the same cycle; p1_stall_o=0.
  - A write updates the word at the edge and sets dirty.
  - The LRU bit is set to the other way.
  - hit_cnt increments once per hit cycle.
- IDLE, miss:
  - p1_stall_o rises combinationally in the same cycle; miss_cnt increments.
  - Victim choice: first invalid way, way 0 preferred; otherwise the LRU way.
  - Victim is valid and dirty -> go to WRITEBACK. Otherwise -> go to ALLOCATE.
  - The victim way is latched for the rest of the miss.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, OFF zeros}, mem_data_o=victim line.
  - Outputs hold stable until mem_ack_i. On ack: wb_cnt increments, the victim's dirty bit clears, go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o=request line address.
  - On ack: mem_data_i is written into the victim way, valid=1, dirty=0, tag written, LRU set to the other way; go to IDLE.
- Replay: after the refill the request is re-evaluated in IDLE as a hit, so the stall drops on that cycle and hit_cnt also increments.
  - Clean miss latency: ack delay + 1 cycle.
  - Dirty miss latency: both ack delays + 1 cycle.
- p1_stall_o = (p1_MemRead_i | p1_MemWrite_i) & (state != IDLE | miss). No request means no stall.
- If the request drops mid-miss, the external transaction in progress and any following ALLOCATE still complete. No counter changes beyond those already made.
- mem_ack_i received in IDLE is ignored.
- p1_data_o is 0 when there is no read hit.
- Request address and data must stay stable while stalled; the pipeline guarantees this.

Test Plan:
1. Reset, then read 0x0000_0040 -> stall high; ALLOCATE read at 0x0000_0040; ack after 10 cycles with line word2=0xDEADBEEF; read 0x0000_0048 in the next cycle -> 0xDEADBEEF, stall 0; miss_cnt=1, hit_cnt=2.
2. Write 0x12345678 to 0x0000_0044 (hit); with WAYS=2, fill way 1 via read 0x0000_0440, then read 0x0000_0840 (index 2, all tags differ) -> the LRU victim is the dirty way 0 holding tag 0; WRITEBACK at 0x0000_0040 with word1=0x12345678; then ALLOCATE at 0x0000_0840; wb_cnt=1.
3. WAYS=2: reads to 0x040, 0x440, then 0x040 again (hit, LRU now points at way 1), then 0x840 -> the way holding 0x440 is evicted; a following read of 0x040 hits.
4. Assert rst for 1 cycle during WRITEBACK -> mem_enable_o=0 on the next edge, state IDLE, counters 0; a read to 0x040 then misses.
5. p1_MemRead_i and p1_MemWrite_i both high on a hit to 0x040 with data 0xA5A5A5A5 -> treated as a write; dirty set; a later read returns 0xA5A5A5A5.
6. WAYS=1, SETS=8, LINE_BITS=128: reads 0x000 then 0x080 (same index 0) -> the second read evicts the first; no writeback while clean; miss_cnt=2.
